// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage RV32I pipeline
//
// Purpose:
//   Drives the PC and pipeline-register enables plus flush/bubble controls
//   for load-use hazards, taken branches resolved in EX and multi-cycle
//   data-memory accesses. A small FSM covers the boot bubble, memory wait
//   and a sticky memory-timeout fault.
//
// Configuration:
//   STALL_COUNTER_EN - when defined, adds the stall_count output and counter.
//
// Ports:
//   clk, reset_n           pipeline clock, asynchronous active-low reset
//   id_rs1/id_rs2          source register indices of the ID instruction
//   id_uses_rs1/_rs2       ID instruction actually reads that source
//   ex_mem_read, ex_rd     EX instruction is a load, and its destination
//   ex_branch_taken        branch in EX resolved taken
//   mem_req, dmem_ready    MEM stage access in progress / completes this cycle
//   pc_enable .. ex_mem_enable   register load enables
//   if_id_flush, id_ex_flush     NOP/bubble insertion into IF/ID and ID/EX
//   mem_wb_bubble          MEM/WB captures a bubble
//   fault                  sticky memory-timeout error
//   stall_count            stall-cycle counter (STALL_COUNTER_EN only)

module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_enable,
  output logic       if_id_enable,
  output logic       id_ex_enable,
  output logic       ex_mem_enable,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_bubble,
  output logic       fault
`ifdef STALL_COUNTER_EN
  ,
  output logic [CNT_W-1:0] stall_count
`endif
);

  if (CNT_W < 1 || MEM_TIMEOUT < 0) begin : g_bad_params
    $error("pipeline_hazard_controller: CNT_W must be >= 1 and MEM_TIMEOUT >= 0");
  end

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  // Wide enough to hold MEM_TIMEOUT itself (the saturation value).
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

  state_t            state;
  state_t            state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_next;

  logic freeze;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic active;
  logic timeout_hit;

  // A pending access with no completion freezes everything up to EX/MEM;
  // dmem_ready without mem_req has no effect.
  assign freeze   = mem_req & ~dmem_ready;
  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  assign active   = (state == ST_RUN) || (state == ST_MEM_WAIT);

  // wait_cnt holds the number of freeze cycles already completed, so when it
  // reads MEM_TIMEOUT-1 the current cycle is the MEM_TIMEOUT-th one.
  assign timeout_hit = (MEM_TIMEOUT != 0) && freeze && (wait_cnt == WAIT_LAST);

  always_comb begin
    wait_cnt_next = '0;
    if (active && freeze) begin
      wait_cnt_next = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (freeze) begin
          state_next = timeout_hit ? ST_FAULT : ST_MEM_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          state_next = timeout_hit ? ST_FAULT : ST_MEM_WAIT;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_FAULT: state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_BOOT;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Output resolution: boot, fault, freeze, branch, load-use, normal.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    id_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    fault         = 1'b0;

    if (state == ST_BOOT) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (state == ST_FAULT) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_bubble = 1'b1;
      fault         = 1'b1;
    end else if (freeze) begin
      // Branch and load-use are held off; they re-evaluate when the access completes.
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // The ID instruction is discarded, so any load-use against it is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID one cycle; ID/EX loads a bubble while the load advances.
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      id_ex_flush  = 1'b1;
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (active && !pc_enable) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - self-checking bench for pipeline_hazard_controller

module tb_pipeline_hazard_controller;

  localparam int TIMEOUT  = 4;
  localparam int TB_CNT_W = 16;

  logic       clk;
  logic       reset_n;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       dmem_ready;
  logic       pc_enable;
  logic       if_id_enable;
  logic       id_ex_enable;
  logic       ex_mem_enable;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_bubble;
  logic       fault;
`ifdef STALL_COUNTER_EN
  logic [TB_CNT_W-1:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: plain counters describing pipeline condition.
  bit m_boot;
  bit m_fault;
  int m_consec;
  int m_stall;

  pipeline_hazard_controller #(
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (TB_CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .dmem_ready     (dmem_ready),
    .pc_enable      (pc_enable),
    .if_id_enable   (if_id_enable),
    .id_ex_enable   (id_ex_enable),
    .ex_mem_enable  (ex_mem_enable),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .mem_wb_bubble  (mem_wb_bubble),
    .fault          (fault)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, mem_wb_bubble, fault}
  function automatic logic [7:0] obs();
    return {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
            if_id_flush, id_ex_flush, mem_wb_bubble, fault};
  endfunction

  function automatic logic [7:0] exp_out();
    bit frz;
    bit hazard;
    frz    = mem_req && !dmem_ready;
    hazard = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (m_boot)          return 8'b0000_1110;
    if (m_fault)         return 8'b0000_0011;
    if (frz)             return 8'b0000_0010;
    if (ex_branch_taken) return 8'b1111_1100;
    if (hazard)          return 8'b0011_0100;
    return 8'b1111_0000;
  endfunction

  function automatic void model_reset();
    m_boot   = 1'b1;
    m_fault  = 1'b0;
    m_consec = 0;
    m_stall  = 0;
  endfunction

  // Applies one clock edge of the rules to the model, using the inputs held across that edge.
  function automatic void model_edge();
    logic [7:0] e;
    e = exp_out();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_fault) begin
      if (!e[7]) m_stall++;
      if (mem_req && !dmem_ready) begin
        m_consec++;
        if (TIMEOUT != 0 && m_consec >= TIMEOUT) m_fault = 1'b1;
      end else begin
        m_consec = 0;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0;
    mem_req = 0; dmem_ready = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #2;
    checks++;
    if (obs() !== exp_out()) begin
      failures++;
      $display("FAIL reset_held got=%b exp=%b", obs(), exp_out());
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    for (int k = 0; k < 2; k++) begin
      // k=0: real hazard on x5; k=1: load targets x0, no stall expected.
      set_idle();
      ex_mem_read = 1; ex_rd = (k == 0) ? 5'd5 : 5'd0;
      id_rs2 = ex_rd; id_uses_rs2 = 1;
      id_rs1 = 5'd9; id_uses_rs1 = 1;
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL load_use k=%0d got=%b exp=%b", k, obs(), exp_out());
      end
      tick();
      ex_mem_read = 0;
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL load_use_after k=%0d got=%b exp=%b", k, obs(), exp_out());
      end
      tick();
    end
    // Hazard through rs1 only.
    set_idle();
    ex_mem_read = 1; ex_rd = 5'd17; id_rs1 = 5'd17; id_uses_rs1 = 1;
    #1;
    checks++;
    if (obs() !== 8'b0011_0100) begin
      failures++;
      $display("FAIL load_use_rs1 got=%b exp=%b", obs(), 8'b0011_0100);
    end
    tick();
  endtask

  task automatic test_branch_over_load_use();
    set_idle();
    ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1; ex_branch_taken = 1;
    #1;
    checks++;
    if (obs() !== exp_out()) begin
      failures++;
      $display("FAIL branch_over_lu got=%b exp=%b", obs(), exp_out());
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int start_stall;
    set_idle();
    start_stall = m_stall;
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL mem_wait cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      tick();
    end
    set_idle();
    #1;
    checks++;
    if (obs() !== 8'b1111_0000) begin
      failures++;
      $display("FAIL mem_wait_resume got=%b exp=%b", obs(), 8'b1111_0000);
    end
`ifdef STALL_COUNTER_EN
    checks++;
    if (stall_count !== TB_CNT_W'(start_stall + 3)) begin
      failures++;
      $display("FAIL mem_wait_stall_count got=%0d exp=%0d", stall_count, start_stall + 3);
    end
`endif
    tick();
  endtask

  task automatic test_branch_during_freeze();
    set_idle();
    mem_req = 1; ex_branch_taken = 1;
    for (int i = 0; i < 3; i++) begin
      dmem_ready = (i == 2);
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL branch_freeze cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_timeout();
    set_idle();
    mem_req = 1;
    for (int i = 0; i < TIMEOUT + 2; i++) begin
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL timeout cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    checks++;
    if (fault !== 1'b1 || obs() !== exp_out()) begin
      failures++;
      $display("FAIL timeout_sticky got=%b exp=%b", obs(), exp_out());
    end
    tick();
    // Asynchronous reset away from any clock edge.
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== 8'b0000_1110) begin
      failures++;
      $display("FAIL timeout_reset got=%b exp=%b", obs(), 8'b0000_1110);
    end
    @(negedge clk);
    set_idle();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_idle();
    mem_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL midwait cyc=%0d got=%b exp=%b", i, obs(), exp_out());
      end
      tick();
    end
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== exp_out()) begin
      failures++;
      $display("FAIL midwait_reset got=%b exp=%b", obs(), exp_out());
    end
    @(negedge clk);
    set_idle();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_mem_read     = ($urandom_range(0, 99) < 40);
      ex_rd           = 5'($urandom_range(0, 3));
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      mem_req         = ($urandom_range(0, 99) < 35);
      dmem_ready      = ($urandom_range(0, 99) < 55);
      #1;
      checks++;
      if (obs() !== exp_out()) begin
        failures++;
        $display("FAIL random n=%0d got=%b exp=%b", n, obs(), exp_out());
      end
`ifdef STALL_COUNTER_EN
      checks++;
      if (stall_count !== TB_CNT_W'(m_stall)) begin
        failures++;
        $display("FAIL random_stall_count n=%0d got=%0d exp=%0d", n, stall_count, m_stall);
      end
`endif
      tick();
      if (m_fault && $urandom_range(0, 3) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #2;
        reset_n = 1'b1;
        @(negedge clk);
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_mem_wait();
    test_branch_during_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
